spmv_fifo_rr_arbiter: RTL and testbench

- Round-robin read scheduler that shares one downstream consumer (multiply/accumulate stage) between NUM_LANES nonzero-entry FIFOs in the SpMV datapath.
- Drives each FIFO's read enable, accounts for the FIFO's 1-cycle registered read latency, and buffers results in a 2-entry output queue with valid/ready handshake.
- Sustains one entry per cycle when the consumer is always ready.

---
 rtl/spmv_fifo_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_spmv_fifo_rr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_fifo_rr_arbiter.sv
// spmv_fifo_rr_arbiter
//   Round-robin read scheduler sharing one downstream MAC stage between
//   NUM_LANES nonzero-entry FIFOs. Issues at most one FIFO read per cycle,
//   absorbs the FIFO's 1-cycle registered read latency, and buffers results
//   in a 2-entry output queue with a valid/ready handshake.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   enable         permits new FIFO reads; in-flight reads always complete
//   lane_mask      per-lane arbitration eligibility
//   fifo_empty     per-lane FIFO empty flags
//   fifo_data      per-lane FIFO read data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rd_en     one-hot-or-zero per-lane read enable
//   out_valid      output queue head is valid
//   out_data       head entry data
//   out_lane       head entry source lane
//   out_ready      consumer accepts the head entry
//   busy           read in flight or output queue non-empty
module spmv_fifo_rr_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_W     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NUM_LANES-1:0]            lane_mask,
  input  logic [NUM_LANES-1:0]            fifo_empty,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_LANES-1:0]            fifo_rd_en,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [LANE_W-1:0]               out_lane,
  input  logic                            out_ready,
  output logic                            busy
);

  logic [LANE_W-1:0]     r_ptr;
  logic                  r_inflight;
  logic [LANE_W-1:0]     r_if_lane;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_q_data [2];
  logic [LANE_W-1:0]     r_q_lane [2];

  logic [NUM_LANES-1:0]  w_elig;
  logic                  w_found;
  logic [LANE_W-1:0]     w_grant;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic [DATA_WIDTH-1:0] w_cap_data;

  assign w_elig    = lane_mask & ~fifo_empty;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_q_data[0];
  assign out_lane  = r_q_lane[0];
  assign busy      = r_inflight | (r_count != 2'd0);
  assign w_pop     = out_valid & out_ready;

  // First eligible lane searching upward from the priority pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      idx = (32'(r_ptr) + k) % NUM_LANES;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_grant = LANE_W'(idx);
      end
    end
  end

  // Occupancy after this cycle's pop; at most 2 entries queued plus in flight.
  // Gating with rst_n keeps read enables low for the whole reset window.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = rst_n & enable & w_found & (w_occ < 3'd2);

  always_comb begin
    fifo_rd_en = '0;
    if (w_issue) fifo_rd_en[w_grant] = 1'b1;
  end

  always_comb begin
    w_cap_data = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (LANE_W'(k) == r_if_lane) w_cap_data = fifo_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_inflight <= 1'b0;
      r_if_lane  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_lane <= w_grant;
        r_ptr     <= (w_grant == LANE_W'(NUM_LANES - 1)) ? '0 : w_grant + 1'b1;
      end
    end
  end

  // Slot 0 is always the head; a pop shifts slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_lane[0] <= '0;
      r_q_lane[1] <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_q_data[0] <= w_cap_data;
            r_q_lane[0] <= r_if_lane;
          end else begin
            r_q_data[1] <= w_cap_data;
            r_q_lane[1] <= r_if_lane;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_q_data[0] <= r_q_data[1];
          r_q_lane[0] <= r_q_lane[1];
          r_count     <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q_data[0] <= w_cap_data;
            r_q_lane[0] <= r_if_lane;
          end else begin
            r_q_data[0] <= r_q_data[1];
            r_q_lane[0] <= r_q_lane[1];
            r_q_data[1] <= w_cap_data;
            r_q_lane[1] <= r_if_lane;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_fifo_rr_arbiter.sv
// Bench for spmv_fifo_rr_arbiter: simple source FIFOs with registered read,
// a queue-level reference model checked every cycle, and directed scenarios
// with literal expectations on grant order and delivered entries.
module tb_spmv_fifo_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  lane_mask = '0;
  logic [N-1:0]  fifo_empty;
  logic [N-1:0]  fifo_rd_en;
  logic [N*DW-1:0] fifo_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_lane;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  spmv_fifo_rr_arbiter #(.NUM_LANES(N), .DATA_WIDTH(DW), .LANE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lane_mask(lane_mask),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFOs: storage written by the stimulus, read pointer advanced here.
  logic [DW-1:0] fmem [N][32];
  int            wp [N] = '{default: 0};
  int            rp [N] = '{default: 0};
  logic [DW-1:0] fdout [N] = '{default: '0};

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]          = (wp[i] == rp[i]);
      fifo_data[i*DW +: DW]  = fdout[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fifo_rd_en[i] && (wp[i] != rp[i])) begin
        fdout[i] <= fmem[i][rp[i]];
        rp[i]    <= rp[i] + 1;
      end
    end
  end

  task automatic preload(input int lane, input logic [DW-1:0] d);
    fmem[lane][wp[lane]] = d;
    wp[lane] = wp[lane] + 1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: priority pointer, in-flight entry, output queue.
  int           m_ptr = 0;
  bit           m_if_v = 1'b0;
  logic [33:0]  m_if_e = '0;
  logic [33:0]  mq [$];
  int           mg;
  bit           mfound, mpop, missue;
  logic [N-1:0] mexp;

  int          glog [$];
  logic [33:0] dlog [$];
  int          vcyc [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr  = 0;
      m_if_v = 1'b0;
      mq.delete();
      chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
    end else begin
      mfound = 1'b0;
      mg     = 0;
      for (int k = 0; k < N; k++) begin
        if (!mfound && lane_mask[(m_ptr + k) % N] && !fifo_empty[(m_ptr + k) % N]) begin
          mfound = 1'b1;
          mg     = (m_ptr + k) % N;
        end
      end
      mpop   = (mq.size() > 0) && out_ready;
      missue = enable && mfound && ((mq.size() + int'(m_if_v) - int'(mpop)) < 2);
      mexp   = missue ? (N'(1) << mg) : '0;

      chk("rd_en", 64'(fifo_rd_en), 64'(mexp));
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(mq[0][31:0]));
        chk("out_lane", 64'(out_lane), 64'(mq[0][33:32]));
      end
      chk("busy", 64'(busy), 64'(m_if_v || (mq.size() > 0)));

      for (int k = 0; k < N; k++) if (fifo_rd_en[k]) glog.push_back(k);
      if (out_valid) vcyc.push_back(cyc);
      if (out_valid && out_ready) dlog.push_back({out_lane, out_data});

      if (mpop) void'(mq.pop_front());
      if (m_if_v) mq.push_back(m_if_e);
      m_if_v = missue;
      if (missue) begin
        m_if_e = {2'(mg), fmem[mg][rp[mg]]};
        m_ptr  = (mg + 1) % N;
      end
      chk("qcount_le2", 64'(mq.size() <= 2), 64'(1));
    end
  end

  function automatic int gl(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction
  function automatic logic [33:0] dl(input int k);
    return (k < dlog.size()) ? dlog[k] : '1;
  endfunction
  function automatic int vc(input int k);
    return (k < vcyc.size()) ? vcyc[k] : -1;
  endfunction

  task automatic clear_logs();
    glog.delete();
    dlog.delete();
    vcyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int first_cyc;
  int s1_lane [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int s1_data [8] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hB0, 'hB1, 'hB2, 'hB3};
  int s2_lane [4] = '{3, 1, 3, 1};
  int s2_data [4] = '{'h63, 'h61, 'h73, 'h71};
  int s3_lane [4] = '{2, 3, 0, 1};

  initial begin
    lane_mask = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("reset_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_data", 64'(out_data), 64'(0));
    chk("reset_lane", 64'(out_lane), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    tick(2);
    rst_n = 1'b1;

    // Round-robin over four loaded lanes.
    for (int i = 0; i < N; i++) begin
      preload(i, 32'hA0 + 32'(i));
      preload(i, 32'hB0 + 32'(i));
    end
    clear_logs();
    first_cyc = cyc;
    enable = 1'b1;
    tick(14);
    chk("s1_grants", 64'(glog.size()), 64'(8));
    chk("s1_deliv", 64'(dlog.size()), 64'(8));
    for (int k = 0; k < 8; k++) begin
      chk("s1_grant_lane", 64'(gl(k)), 64'(s1_lane[k]));
      chk("s1_entry", 64'(dl(k)), 64'({2'(s1_lane[k]), 32'(s1_data[k])}));
    end
    chk("s1_valid_cnt", 64'(vcyc.size()), 64'(8));
    chk("s1_first_valid", 64'(vc(0)), 64'(first_cyc + 2));
    chk("s1_last_valid", 64'(vc(7)), 64'(first_cyc + 9));

    // Move the pointer to 2 via a single lane-1 grant, then sparse lanes 1 and 3.
    enable = 1'b0;
    lane_mask = 4'b0010;
    preload(1, 32'h51);
    enable = 1'b1;
    tick(6);
    enable = 1'b0;
    lane_mask = 4'hF;
    preload(1, 32'h61); preload(1, 32'h71);
    preload(3, 32'h63); preload(3, 32'h73);
    clear_logs();
    enable = 1'b1;
    tick(12);
    chk("s2_grants", 64'(glog.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("s2_grant_lane", 64'(gl(k)), 64'(s2_lane[k]));
      chk("s2_entry", 64'(dl(k)), 64'({2'(s2_lane[k]), 32'(s2_data[k])}));
    end

    // Backpressure: two reads outstanding, head holds, then drain.
    enable = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) preload(i, 32'hC0 + 32'(i));
    clear_logs();
    enable = 1'b1;
    tick(8);
    chk("s3_stalled_grants", 64'(glog.size()), 64'(2));
    chk("s3_valid", 64'(out_valid), 64'(1));
    chk("s3_hold_data", 64'(out_data), 64'(32'hC2));
    chk("s3_hold_lane", 64'(out_lane), 64'(2));
    tick(3);
    chk("s3_hold_data2", 64'(out_data), 64'(32'hC2));
    chk("s3_hold_lane2", 64'(out_lane), 64'(2));
    chk("s3_still_stalled", 64'(glog.size()), 64'(2));
    out_ready = 1'b1;
    tick(12);
    chk("s3_grants", 64'(glog.size()), 64'(4));
    chk("s3_deliv", 64'(dlog.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      chk("s3_entry", 64'(dl(k)), 64'({2'(s3_lane[k]), 32'hC0 + 32'(s3_lane[k])}));

    // Single-entry lane: exactly one read despite staying enabled.
    enable = 1'b0;
    preload(2, 32'hD2);
    clear_logs();
    enable = 1'b1;
    tick(8);
    chk("s4_grants", 64'(glog.size()), 64'(1));
    chk("s4_grant_lane", 64'(gl(0)), 64'(2));
    chk("s4_deliv", 64'(dlog.size()), 64'(1));
    chk("s4_entry", 64'(dl(0)), 64'({2'd2, 32'hD2}));
    chk("s4_empty2", 64'(fifo_empty[2]), 64'(1));

    // Enable dropped the cycle after an issue.
    enable = 1'b0;
    tick(1);
    preload(3, 32'hE3);
    preload(0, 32'hE0);
    clear_logs();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    #1;
    chk("s5_no_rd", 64'(fifo_rd_en), 64'(0));
    chk("s5_busy_inflight", 64'(busy), 64'(1));
    tick(1);
    chk("s5_valid", 64'(out_valid), 64'(1));
    chk("s5_data", 64'(out_data), 64'(32'hE3));
    tick(2);
    chk("s5_busy_low", 64'(busy), 64'(0));
    chk("s5_grants", 64'(glog.size()), 64'(1));
    chk("s5_entry", 64'(dl(0)), 64'({2'd3, 32'hE3}));
    chk("s5_lane0_kept", 64'(fifo_empty[0]), 64'(0));

    // Async reset with two queued entries, then restart from lane 0.
    out_ready = 1'b0;
    preload(1, 32'hF1);
    preload(2, 32'hF2);
    clear_logs();
    enable = 1'b1;
    tick(6);
    chk("s6_valid_pre", 64'(out_valid), 64'(1));
    chk("s6_head_pre", 64'({out_lane, out_data}), 64'({2'd0, 32'hE0}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", 64'(out_valid), 64'(0));
    chk("s6_rst_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("s6_rst_busy", 64'(busy), 64'(0));
    enable = 1'b0;
    tick(2);
    preload(0, 32'h90);
    preload(3, 32'h93);
    rst_n = 1'b1;
    clear_logs();
    out_ready = 1'b1;
    enable = 1'b1;
    tick(10);
    chk("s6_grants", 64'(glog.size()), 64'(3));
    chk("s6_g0", 64'(gl(0)), 64'(0));
    chk("s6_g1", 64'(gl(1)), 64'(2));
    chk("s6_g2", 64'(gl(2)), 64'(3));
    chk("s6_e0", 64'(dl(0)), 64'({2'd0, 32'h90}));
    chk("s6_e1", 64'(dl(1)), 64'({2'd2, 32'hF2}));
    chk("s6_e2", 64'(dl(2)), 64'({2'd3, 32'h93}));

    enable = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
